// File: rtl/fpu_mul_share_arbiter.sv
// Shares one fixed-latency, non-stallable FPU multiplier among NUM_REQ
// requesters. Round-robin grant with at most one issue per cycle. A tag shift
// register that runs alongside the multiplier pipeline steers each product
// back to the requester that issued it.
module fpu_mul_share_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int SIZE_DATA = 32,
    parameter int MUL_LAT   = 3
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_hold,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    input  logic [NUM_REQ*SIZE_DATA-1:0]   i_req_a,
    input  logic [NUM_REQ*SIZE_DATA-1:0]   i_req_b,
    output logic [NUM_REQ-1:0]             o_req_ready,
    output logic                           o_mul_valid,
    output logic [SIZE_DATA-1:0]           o_mul_a,
    output logic [SIZE_DATA-1:0]           o_mul_b,
    input  logic [SIZE_DATA-1:0]           i_mul_result,
    output logic [NUM_REQ-1:0]             o_rsp_valid,
    output logic [SIZE_DATA-1:0]           o_rsp_data,
    output logic                           o_busy
);
    localparam int TAG_W = $clog2(NUM_REQ);
    // Holds MUL_LAT+2 in-flight ops (accept cycle through response cycle).
    localparam int CNT_W = $clog2(MUL_LAT + 3);

    // Flat operand buses viewed as one slot per requester.
    logic [NUM_REQ-1:0][SIZE_DATA-1:0] req_a;
    logic [NUM_REQ-1:0][SIZE_DATA-1:0] req_b;
    assign req_a = i_req_a;
    assign req_b = i_req_b;

    logic [TAG_W-1:0]               ptr;
    logic [NUM_REQ-1:0]             grant;
    logic [TAG_W-1:0]               gnt_idx;
    logic                           accept;
    logic [MUL_LAT:0]               vld_pipe;
    logic [MUL_LAT:0][TAG_W-1:0]    tag_pipe;
    logic [CNT_W-1:0]               cnt;
    logic [CNT_W-1:0]               cnt_next;
    logic                           rsp_any;

    // Round-robin search starting at ptr; suppressed during reset or hold.
    always_comb begin
        logic             found;
        logic [TAG_W-1:0] idx;
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = TAG_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && i_req_valid[idx]) begin
                found        = 1'b1;
                grant[idx]   = 1'b1;
                gnt_idx      = idx;
            end
        end
        if (i_rst || i_hold) begin
            grant = '0;
        end
    end

    assign o_req_ready = grant;
    assign accept      = |grant;
    assign rsp_any     = |o_rsp_valid;

    // Pointer moves just past the winner so every requester gets a turn.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : gnt_idx + TAG_W'(1);
        end
    end

    // Issue register; operands hold their last value when nothing is issued.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_mul_valid <= 1'b0;
            o_mul_a     <= '0;
            o_mul_b     <= '0;
        end else begin
            o_mul_valid <= accept;
            if (accept) begin
                o_mul_a <= req_a[gnt_idx];
                o_mul_b <= req_b[gnt_idx];
            end
        end
    end

    // Tag pipe mirrors the multiplier: the tail lines up with i_mul_result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[MUL_LAT-1:0], accept};
            tag_pipe <= {tag_pipe[MUL_LAT-1:0], gnt_idx};
        end
    end

    // Capture the product at the tail and strobe its owner for one cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rsp_valid <= '0;
            o_rsp_data  <= '0;
        end else begin
            o_rsp_valid <= '0;
            if (vld_pipe[MUL_LAT]) begin
                o_rsp_valid[tag_pipe[MUL_LAT]] <= 1'b1;
                o_rsp_data                     <= i_mul_result;
            end
        end
    end

    // In-flight count: accept adds, response strobe retires.
    always_comb begin
        cnt_next = cnt;
        case ({accept, rsp_any})
            2'b10:   cnt_next = cnt + CNT_W'(1);
            2'b01:   cnt_next = cnt - CNT_W'(1);
            default: cnt_next = cnt;
        endcase
    end

    // Count and busy flag registered together so busy tracks the new count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt    <= '0;
            o_busy <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            o_busy <= (cnt_next != '0);
        end
    end

endmodule

// File: tb/tb_fpu_mul_share_arbiter.sv
// Bench for fpu_mul_share_arbiter: a toy MUL_LAT-deep multiplier model, a
// continuous scoreboard monitor, a vector table for the arbitration order and
// hand-written sequences for hold, reset and back-to-back traffic.
module tb_fpu_mul_share_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int SIZE_DATA = 32;
    localparam int MUL_LAT   = 3;
    localparam int LAT       = MUL_LAT + 2;

    logic                              i_clk = 1'b0;
    logic                              i_rst;
    logic                              i_hold;
    logic [NUM_REQ-1:0]                i_req_valid;
    logic [NUM_REQ-1:0][SIZE_DATA-1:0] a_arr;
    logic [NUM_REQ-1:0][SIZE_DATA-1:0] b_arr;
    logic [NUM_REQ-1:0]                o_req_ready;
    logic                              o_mul_valid;
    logic [SIZE_DATA-1:0]              o_mul_a;
    logic [SIZE_DATA-1:0]              o_mul_b;
    logic [SIZE_DATA-1:0]              mul_result;
    logic [NUM_REQ-1:0]                o_rsp_valid;
    logic [SIZE_DATA-1:0]              o_rsp_data;
    logic                              o_busy;

    fpu_mul_share_arbiter #(.NUM_REQ(NUM_REQ), .SIZE_DATA(SIZE_DATA), .MUL_LAT(MUL_LAT)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_hold(i_hold),
        .i_req_valid(i_req_valid), .i_req_a(a_arr), .i_req_b(b_arr),
        .o_req_ready(o_req_ready), .o_mul_valid(o_mul_valid),
        .o_mul_a(o_mul_a), .o_mul_b(o_mul_b), .i_mul_result(mul_result),
        .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int vectors = 0;
    int errs    = 0;
    int cyc     = 0;
    bit mon_en  = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Toy single-precision multiply for normal operands, truncating.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        logic [9:0]  e;
        m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
        if (m[47]) begin
            e = e + 10'd1;
            return {a[31] ^ b[31], e[7:0], m[46:24]};
        end
        return {a[31] ^ b[31], e[7:0], m[45:23]};
    endfunction

    function automatic logic [31:0] rnd_f();
        logic [31:0] r;
        r = $urandom;
        r[30:23] = 8'(100 + $urandom_range(0, 50));
        return r;
    endfunction

    // Multiplier model: fixed latency, not reset, garbage when idle.
    logic [SIZE_DATA-1:0] fpu_pipe [MUL_LAT];
    always @(posedge i_clk) begin
        fpu_pipe[0] <= o_mul_valid ? fmul(o_mul_a, o_mul_b) : 32'hDEAD_BEEF;
        for (int i = 1; i < MUL_LAT; i++) fpu_pipe[i] <= fpu_pipe[i-1];
    end
    assign mul_result = fpu_pipe[MUL_LAT-1];

    // Scoreboard monitor: own RR pointer, in-flight count and response queue.
    typedef struct { int req; logic [31:0] data; int cyc; } sb_t;
    sb_t         q[$];
    int          mptr = 0;
    int          mcnt = 0;
    logic        exp_mv = 1'b0;
    logic [31:0] exp_ma = '0;
    logic [31:0] exp_mb = '0;

    always @(negedge i_clk) begin
        logic [3:0] er;
        int         k;
        int         j;
        sb_t        e;
        if (mon_en) begin
            er = '0;
            k  = -1;
            if (!i_rst && !i_hold) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    j = (mptr + i) % NUM_REQ;
                    if (k < 0 && i_req_valid[j]) k = j;
                end
            end
            if (k >= 0) er[k] = 1'b1;
            check("mon_ready", 32'(o_req_ready), 32'(er));
            check("mon_mul_valid", 32'(o_mul_valid), 32'(exp_mv));
            if (exp_mv) begin
                check("mon_mul_a", o_mul_a, exp_ma);
                check("mon_mul_b", o_mul_b, exp_mb);
            end
            check("mon_busy", 32'(o_busy), 32'(mcnt != 0));
            if (o_rsp_valid != '0) begin
                if (q.size() == 0) begin
                    check("mon_spurious_rsp", 32'(o_rsp_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("mon_rsp_who", 32'(o_rsp_valid), 32'(1 << e.req));
                    check("mon_rsp_data", o_rsp_data, e.data);
                    check("mon_rsp_latency", cyc - e.cyc, LAT);
                end
            end
            if (q.size() > 0 && (cyc - q[0].cyc) > LAT) begin
                check("mon_rsp_missing_age", cyc - q[0].cyc, LAT);
                void'(q.pop_front());
            end
            mcnt   = mcnt + ((k >= 0) ? 1 : 0) - ((o_rsp_valid != '0) ? 1 : 0);
            exp_mv = (k >= 0);
            if (k >= 0) begin
                exp_ma = a_arr[k];
                exp_mb = b_arr[k];
                q.push_back('{k, fmul(a_arr[k], b_arr[k]), cyc});
                mptr = (k + 1) % NUM_REQ;
            end
            if (i_rst) begin
                q.delete();
                mptr   = 0;
                mcnt   = 0;
                exp_mv = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_req_valid = '0;
        i_hold = 1'b0;
        step();
        step();
        i_rst = 1'b0;
    endtask

    typedef struct { logic hold; logic [3:0] valid; logic [3:0] exp; } vec_t;
    vec_t tbl [12];

    initial begin
        // Arbitration table, pointer walked by hand from 0 after reset.
        tbl[0]  = '{1'b0, 4'b0000, 4'b0000};  // ptr 0
        tbl[1]  = '{1'b0, 4'b1010, 4'b0010};  // -> ptr 2
        tbl[2]  = '{1'b0, 4'b1010, 4'b1000};  // req3 before req1, ptr -> 0
        tbl[3]  = '{1'b0, 4'b1010, 4'b0010};  // -> ptr 2
        tbl[4]  = '{1'b0, 4'b0011, 4'b0001};  // wraps past 2,3 -> ptr 1
        tbl[5]  = '{1'b1, 4'b1111, 4'b0000};  // hold, ptr stays 1
        tbl[6]  = '{1'b0, 4'b1111, 4'b0010};  // -> ptr 2
        tbl[7]  = '{1'b0, 4'b0100, 4'b0100};  // -> ptr 3
        tbl[8]  = '{1'b0, 4'b1111, 4'b1000};  // -> ptr 0
        tbl[9]  = '{1'b0, 4'b0001, 4'b0001};  // -> ptr 1
        tbl[10] = '{1'b0, 4'b0001, 4'b0001};  // only req0 -> ptr 1
        tbl[11] = '{1'b0, 4'b1100, 4'b0100};  // -> ptr 3

        i_rst = 1'b1; i_hold = 1'b0; i_req_valid = '0; a_arr = '0; b_arr = '0;
        step(); step();
        mon_en = 1'b1;
        @(negedge i_clk);
        check("reset_ready", 32'(o_req_ready), 32'd0);
        check("reset_mul_valid", 32'(o_mul_valid), 32'd0);
        check("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("reset_rsp_data", o_rsp_data, 32'd0);
        check("reset_busy", 32'(o_busy), 32'd0);
        step();
        i_rst = 1'b0;
        repeat (3) step();

        // Single request 2.0 * 3.0 from req0.
        a_arr[0] = 32'h4000_0000; b_arr[0] = 32'h4040_0000;
        i_req_valid = 4'b0001;
        @(negedge i_clk);
        check("t1_ready", 32'(o_req_ready), 32'h1);
        step();
        i_req_valid = '0;
        @(negedge i_clk);
        check("t1_mul_valid", 32'(o_mul_valid), 32'h1);
        check("t1_mul_a", o_mul_a, 32'h4000_0000);
        check("t1_mul_b", o_mul_b, 32'h4040_0000);
        for (int d = 2; d <= 7; d++) begin
            step();
            @(negedge i_clk);
            check("t1_rsp_valid", 32'(o_rsp_valid), (d == 5) ? 32'h1 : 32'h0);
            if (d == 5) check("t1_rsp_data", o_rsp_data, 32'h40C0_0000);
            if (d == 2) check("t1_busy_on", 32'(o_busy), 32'h1);
            if (d == 7) check("t1_busy_off", 32'(o_busy), 32'h0);
        end
        step();

        // All four valid continuously: 0,1,2,3,... with back-to-back strobes.
        do_reset();
        for (int k = 0; k < NUM_REQ; k++) begin
            a_arr[k] = 32'h3F80_0000 | 32'(k << 12);
            b_arr[k] = 32'h4000_0000 | 32'(k << 16);
        end
        i_req_valid = 4'b1111;
        for (int j = 0; j <= 12 + LAT; j++) begin
            if (j == 12) i_req_valid = '0;
            @(negedge i_clk);
            if (j < 12) check("t2_ready", 32'(o_req_ready), 32'(1 << (j % 4)));
            check("t2_rsp_valid", 32'(o_rsp_valid),
                  (j >= LAT && j - LAT < 12) ? 32'(1 << ((j - LAT) % 4)) : 32'h0);
            step();
        end

        // Table of arbitration vectors.
        do_reset();
        for (int k = 0; k < NUM_REQ; k++) begin
            a_arr[k] = 32'h4100_0000 | 32'(k << 8);
            b_arr[k] = 32'h3F00_0000 | 32'(k << 4);
        end
        for (int v = 0; v < 12; v++) begin
            i_hold = tbl[v].hold;
            i_req_valid = tbl[v].valid;
            @(negedge i_clk);
            check($sformatf("tbl%0d_ready", v), 32'(o_req_ready), 32'(tbl[v].exp));
            step();
        end
        i_hold = 1'b0; i_req_valid = '0;
        repeat (LAT + 2) step();

        // Hold after two accepts: both drain, no issue, resume at ptr 2.
        do_reset();
        for (int j = 0; j <= 8; j++) begin
            i_hold = (j >= 2 && j <= 7);
            i_req_valid = (j < 2) ? 4'b0011 : 4'b1111;
            @(negedge i_clk);
            check("t4_ready", 32'(o_req_ready), (j == 0) ? 32'h1 : (j == 1) ? 32'h2 : (j == 8) ? 32'h4 : 32'h0);
            if (j >= 3 && j <= 7) check("t4_no_issue", 32'(o_mul_valid), 32'h0);
            check("t4_rsp_valid", 32'(o_rsp_valid), (j == 5) ? 32'h1 : (j == 6) ? 32'h2 : 32'h0);
            step();
        end
        i_hold = 1'b0; i_req_valid = '0;
        repeat (LAT + 2) step();

        // Reset two cycles after an accept discards the op and the pointer.
        do_reset();
        i_req_valid = 4'b0100;
        @(negedge i_clk);
        check("t5_ready", 32'(o_req_ready), 32'h4);
        step();
        i_req_valid = '0;
        step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        @(negedge i_clk);
        check("t5_mul_valid", 32'(o_mul_valid), 32'h0);
        check("t5_busy", 32'(o_busy), 32'h0);
        for (int j = 0; j < 8; j++) begin
            @(negedge i_clk);
            check("t5_no_rsp", 32'(o_rsp_valid), 32'h0);
            step();
        end
        i_req_valid = 4'b1111;
        @(negedge i_clk);
        check("t5_ptr_reset", 32'(o_req_ready), 32'h1);
        step();
        i_req_valid = '0;
        repeat (LAT + 2) step();

        // Random traffic against the scoreboard.
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                a_arr[k] = rnd_f();
                b_arr[k] = rnd_f();
            end
            i_req_valid = 4'($urandom);
            i_hold = ($urandom_range(0, 15) == 0);
            step();
        end
        i_req_valid = '0; i_hold = 1'b0;
        for (int c = 0; c < 20 && q.size() != 0; c++) step();
        check("drain_queue_empty", 32'(q.size()), 32'd0);
        @(negedge i_clk);
        check("drain_busy", 32'(o_busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
